// File: rtl/mul_red_pkg.sv
// Shared constants and types for the K/D multiply-reduce issuer.
package mul_red_pkg;

  localparam int unsigned DATA_W      = 24;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned DILITHIUM_Q = 8380417;

  localparam logic             MODE_K   = 1'b0;
  localparam logic             MODE_D   = 1'b1;
  localparam logic [SEL_W-1:0] SEL_INTT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One slot of the in-flight tracker.
  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // One result FIFO entry.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } res_t;

  // INTT needs the A operand skewed one cycle behind w.
  function automatic logic is_intt(input logic [SEL_W-1:0] sel);
    return sel == SEL_INTT;
  endfunction

endpackage

// File: rtl/mul_red_issuer_if.sv
// Operand stream, multiplier pins and result stream of the issuer.
interface mul_red_issuer_if;
  import mul_red_pkg::*;

  // operand stream
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_w;
  logic              in_mode;
  logic [SEL_W-1:0]  in_sel;
  logic              in_last;

  // multiplier pins
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_w;
  logic [SEL_W-1:0]  mul_sel_a;
  logic              mul_mode;
  logic [DATA_W-1:0] mul_result;

  // result stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Issuer side.
  modport slave (
    input  in_valid, in_a, in_w, in_mode, in_sel, in_last,
    input  mul_result, out_ready,
    output in_ready, mul_a, mul_w, mul_sel_a, mul_mode,
    output out_valid, out_data, out_last
  );

  // Butterfly controller / multiplier / consumer side.
  modport master (
    output in_valid, in_a, in_w, in_mode, in_sel, in_last,
    output mul_result, out_ready,
    input  in_ready, mul_a, mul_w, mul_sel_a, mul_mode,
    input  out_valid, out_data, out_last
  );

endinterface

// File: rtl/mul_red_fifo.sv
// Result FIFO: DEPTH entries of {last, data}, with occupancy count.
module mul_red_fifo
  import mul_red_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  res_t             push_data,
  input  logic             pop,
  output res_t             head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  res_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed: reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/mul_red_issuer.sv
// Issuer/collector for the shared K/D modular multiply-reduce unit.
module mul_red_issuer
  import mul_red_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  mul_red_issuer_if.slave  bus,
  output logic             busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INF_W = $clog2(MUL_LAT + 2);
  localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  state_t            state_q;
  state_t            state_d;
  logic              mode_q;
  logic              mode_d;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;

  // Slot 0 is only used by INTT beats (one extra cycle for the A skew).
  tag_t [MUL_LAT:0]  tag_q;
  logic [DATA_W-1:0] a_dly_q;

  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  res_t              fifo_head;
  res_t              push_data;
  logic              push;
  logic              pop;

  logic              credit_ok;
  logic              pipe_empty;
  logic              in_fire;
  logic              mode_eff;
  logic [SEL_W-1:0]  sel_eff;
  logic              intt;
  tag_t              new_tag;

  // Number of beats issued to the multiplier whose results are not yet captured.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= MUL_LAT; i++) begin
      inflight = inflight + INF_W'(tag_q[i].vld);
    end
  end

  assign pipe_empty = (inflight == '0);
  // The multiplier cannot stall, so every issued beat must already own a FIFO slot.
  assign credit_ok  = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(DEPTH);

  // Burst FSM state register with latched mode/sel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_K;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
    end
  end

  // Next state, accept handshake and the mode/sel presented to the multiplier.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    sel_d        = sel_q;
    mode_eff     = mode_q;
    sel_eff      = sel_q;
    bus.in_ready = rst && (state_q != DRAIN) && credit_ok;
    in_fire      = bus.in_valid && bus.in_ready;

    // The first beat must see its own mode/sel before they are latched.
    if (state_q == IDLE) begin
      mode_eff = in_fire ? bus.in_mode : MODE_K;
      sel_eff  = in_fire ? bus.in_sel  : '0;
    end
    if (!rst) begin
      mode_eff = MODE_K;
      sel_eff  = '0;
    end

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          mode_d  = bus.in_mode;
          sel_d   = bus.in_sel;
          state_d = bus.in_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (in_fire && bus.in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty && fifo_empty) begin
          state_d = IDLE;
          mode_d  = MODE_K;
          sel_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier operand drive; INTT presents A one cycle after its w.
  always_comb begin
    intt          = is_intt(sel_eff);
    new_tag       = tag_t'{vld: 1'b1, last: bus.in_last};
    bus.mul_w     = in_fire ? bus.in_w : '0;
    bus.mul_a     = intt ? a_dly_q : (in_fire ? bus.in_a : '0);
    bus.mul_mode  = mode_eff;
    bus.mul_sel_a = sel_eff;
  end

  // Tag pipe mirrors the multiplier pipeline; delayed A register for INTT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q   <= '0;
      a_dly_q <= '0;
    end else begin
      a_dly_q  <= (in_fire && intt)  ? bus.in_a : '0;
      tag_q[0] <= (in_fire && intt)  ? new_tag  : '0;
      tag_q[1] <= (in_fire && !intt) ? new_tag  : tag_q[0];
      for (int unsigned i = 2; i <= MUL_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Capture the multiplier result as its tag leaves the pipe.
  assign push      = tag_q[MUL_LAT].vld;
  assign push_data = res_t'{last: tag_q[MUL_LAT].last, data: bus.mul_result};
  assign pop       = !fifo_empty && bus.out_ready;

  mul_red_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Result stream from the FIFO head, zeroed when nothing is pending.
  always_comb begin
    bus.out_valid = !fifo_empty;
    bus.out_data  = fifo_empty ? '0 : fifo_head.data;
    bus.out_last  = !fifo_empty && fifo_head.last;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_red_issuer.sv
// Directed testbench for mul_red_issuer with a behavioural multiplier model.
module tb_mul_red_issuer;
  import mul_red_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  mul_red_issuer_if bus();

  mul_red_issuer #(.MUL_LAT(3), .DEPTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Behavioural K/D multiply-reduce: lane-wise mod KYBER_Q, or full mod DILITHIUM_Q.
  function automatic logic [23:0] mulred(input logic [23:0] a, input logic [23:0] w, input logic mode);
    logic [47:0] p;
    logic [47:0] hi;
    logic [47:0] lo;
    if (mode == MODE_D) begin
      p = 48'(a) * 48'(w);
      return 24'(p % 48'(DILITHIUM_Q));
    end
    hi = (48'(a[23:12]) * 48'(w[23:12])) % 48'(KYBER_Q);
    lo = (48'(a[11:0])  * 48'(w[11:0]))  % 48'(KYBER_Q);
    return {12'(hi), 12'(lo)};
  endfunction

  // Three-stage multiplier; in INTT it pairs A with the previous cycle's w.
  logic [23:0] w_dly = '0;
  logic [23:0] p0 = '0;
  logic [23:0] p1 = '0;
  logic [23:0] p2 = '0;
  always @(posedge clk) begin
    w_dly <= bus.mul_w;
    p0    <= mulred(bus.mul_a, (bus.mul_sel_a == SEL_INTT) ? w_dly : bus.mul_w, bus.mul_mode);
    p1    <= p0;
    p2    <= p1;
  end
  assign bus.mul_result = p2;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] w, input logic mode,
                       input logic [1:0] sel, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_w     = w;
    bus.in_mode  = mode;
    bus.in_sel   = sel;
    bus.in_last  = last;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_w     = '0;
    bus.in_mode  = 1'b0;
    bus.in_sel   = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_in();
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b1;
    settle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.mul_a !== 24'h0 || bus.mul_w !== 24'h0) begin errors++; $display("FAIL rst_mul_ops: got a=%h w=%h expected 0", bus.mul_a, bus.mul_w); end
    checks++; if (bus.mul_mode !== 1'b0 || bus.mul_sel_a !== 2'b00) begin errors++; $display("FAIL rst_mul_ctl: got mode=%b sel=%b expected 0", bus.mul_mode, bus.mul_sel_a); end
    checks++; if (bus.out_data !== 24'h0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_data: got %h/%b expected 0", bus.out_data, bus.out_last); end
    idle_in();
    rst = 1'b1;
    tick();
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_k_single();
    int n;
    bus.out_ready = 1'b1;
    drive({12'd5, 12'd7}, {12'd3, 12'd2}, MODE_K, 2'b00, 1'b1);
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL k_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.mul_a !== {12'd5, 12'd7}) begin errors++; $display("FAIL k_mul_a: got %h expected %h", bus.mul_a, {12'd5, 12'd7}); end
    checks++; if (bus.mul_w !== {12'd3, 12'd2}) begin errors++; $display("FAIL k_mul_w: got %h expected %h", bus.mul_w, {12'd3, 12'd2}); end
    checks++; if (bus.mul_mode !== 1'b0 || bus.mul_sel_a !== 2'b00) begin errors++; $display("FAIL k_mul_ctl: got mode=%b sel=%b expected 0/00", bus.mul_mode, bus.mul_sel_a); end
    tick();
    idle_in();
    settle();
    checks++; if (bus.mul_a !== 24'h0 || bus.mul_w !== 24'h0) begin errors++; $display("FAIL k_mul_idle: got a=%h w=%h expected 0", bus.mul_a, bus.mul_w); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL k_busy_drain: got %b expected 1", busy); end
    n = 1;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    checks++; if (bus.out_valid !== 1'b1 || n != 4) begin errors++; $display("FAIL k_latency: got valid=%b after %0d cycles expected 1 after 4", bus.out_valid, n); end
    checks++; if (bus.out_data !== {12'd15, 12'd14}) begin errors++; $display("FAIL k_out_data: got %h expected %h", bus.out_data, {12'd15, 12'd14}); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL k_out_last: got %b expected 1", bus.out_last); end
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL k_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_d_mode();
    int n;
    bus.out_ready = 1'b0;
    drive(24'd1000, 24'd1000, MODE_D, 2'b00, 1'b1);
    settle();
    checks++; if (bus.mul_mode !== 1'b1) begin errors++; $display("FAIL d_mode_first: got %b expected 1", bus.mul_mode); end
    tick();
    idle_in();
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    checks++; if (bus.out_data !== 24'd1000000) begin errors++; $display("FAIL d_out_data: got %0d expected 1000000", bus.out_data); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL d_out_last: got %b expected 1", bus.out_last); end
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 24'd1000000) begin errors++; $display("FAIL d_hold: got valid=%b data=%0d expected 1/1000000", bus.out_valid, bus.out_data); end
    checks++; if (bus.mul_mode !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL d_mode_held: got mode=%b busy=%b expected 1/1", bus.mul_mode, busy); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL d_popped: got valid=%b expected 0", bus.out_valid); end
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy !== 1'b0 || bus.mul_mode !== 1'b0) begin errors++; $display("FAIL d_release: got busy=%b mode=%b expected 0/0", busy, bus.mul_mode); end
  endtask

  task automatic test_intt();
    logic [23:0] a_v [4];
    logic [23:0] w_v [4];
    logic [23:0] exp_v [4];
    logic [23:0] prev_a;
    int j;
    int n;
    a_v[0] = {12'd1, 12'd2};  w_v[0] = {12'd10, 12'd20}; exp_v[0] = {12'd10,  12'd40};
    a_v[1] = {12'd3, 12'd4};  w_v[1] = {12'd30, 12'd40}; exp_v[1] = {12'd90,  12'd160};
    a_v[2] = {12'd5, 12'd6};  w_v[2] = {12'd50, 12'd60}; exp_v[2] = {12'd250, 12'd360};
    a_v[3] = {12'd7, 12'd8};  w_v[3] = {12'd70, 12'd80}; exp_v[3] = {12'd490, 12'd640};
    bus.out_ready = 1'b1;
    prev_a = '0;
    for (int k = 0; k < 4; k++) begin
      drive(a_v[k], w_v[k], MODE_K, SEL_INTT, k == 3);
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL intt_ready%0d: got %b expected 1", k, bus.in_ready); end
      checks++; if (bus.mul_w !== w_v[k]) begin errors++; $display("FAIL intt_mul_w%0d: got %h expected %h", k, bus.mul_w, w_v[k]); end
      checks++; if (bus.mul_a !== prev_a) begin errors++; $display("FAIL intt_mul_a%0d: got %h expected %h", k, bus.mul_a, prev_a); end
      checks++; if (bus.mul_sel_a !== SEL_INTT) begin errors++; $display("FAIL intt_sel%0d: got %b expected 10", k, bus.mul_sel_a); end
      prev_a = a_v[k];
      tick();
    end
    idle_in();
    settle();
    checks++; if (bus.mul_a !== a_v[3] || bus.mul_w !== 24'h0) begin errors++; $display("FAIL intt_tail: got a=%h w=%h expected %h/0", bus.mul_a, bus.mul_w, a_v[3]); end
    j = 0;
    n = 0;
    while (j < 4 && n < 40) begin
      if (bus.out_valid) begin
        checks++; if (bus.out_data !== exp_v[j]) begin errors++; $display("FAIL intt_data%0d: got %h expected %h", j, bus.out_data, exp_v[j]); end
        checks++; if (bus.out_last !== (j == 3)) begin errors++; $display("FAIL intt_last%0d: got %b expected %b", j, bus.out_last, j == 3); end
        j++;
      end
      tick();
      n++;
    end
    checks++; if (j != 4) begin errors++; $display("FAIL intt_count: got %0d results expected 4", j); end
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL intt_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int acc;
    int j;
    int n;
    logic took;
    acc = 0;
    j = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (acc < 12) drive({12'd0, 12'(acc + 1)}, {12'd0, 12'd2}, MODE_K, 2'b00, acc == 11);
      else idle_in();
      settle();
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    settle();
    checks++; if (acc != 8) begin errors++; $display("FAIL bp_accepted: got %0d expected 8", acc); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== {12'd0, 12'd2}) begin errors++; $display("FAIL bp_head: got valid=%b data=%h expected 1/000002", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    n = 0;
    while (j < 12 && n < 100) begin
      if (acc < 12) drive({12'd0, 12'(acc + 1)}, {12'd0, 12'd2}, MODE_K, 2'b00, acc == 11);
      else idle_in();
      settle();
      took = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        checks++; if (bus.out_data !== {12'd0, 12'(2 * (j + 1))}) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", j, bus.out_data, {12'd0, 12'(2 * (j + 1))}); end
        checks++; if (bus.out_last !== (j == 11)) begin errors++; $display("FAIL bp_last%0d: got %b expected %b", j, bus.out_last, j == 11); end
        j++;
      end
      if (took) acc++;
      tick();
      n++;
    end
    idle_in();
    checks++; if (acc != 12 || j != 12) begin errors++; $display("FAIL bp_totals: got accepted=%0d delivered=%0d expected 12/12", acc, j); end
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_mode_hold();
    logic [23:0] exp_v [4];
    logic        ready_seen;
    logic        took;
    logic        new_taken;
    int j;
    int n;
    exp_v[0] = {12'd0, 12'd6};
    exp_v[1] = {12'd0, 12'd9};
    exp_v[2] = {12'd0, 12'd12};
    exp_v[3] = {12'd0, 12'd81};
    bus.out_ready = 1'b0;
    drive({12'd0, 12'd2}, {12'd0, 12'd3}, MODE_K, 2'b00, 1'b0);
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mh_ready0: got %b expected 1", bus.in_ready); end
    tick();
    drive({12'd0, 12'd3}, {12'd0, 12'd3}, MODE_D, SEL_INTT, 1'b0);
    settle();
    checks++; if (bus.mul_mode !== 1'b0 || bus.mul_sel_a !== 2'b00) begin errors++; $display("FAIL mh_ctl_held: got mode=%b sel=%b expected 0/00", bus.mul_mode, bus.mul_sel_a); end
    checks++; if (bus.mul_a !== {12'd0, 12'd3} || bus.mul_w !== {12'd0, 12'd3}) begin errors++; $display("FAIL mh_passthru: got a=%h w=%h expected 000003/000003", bus.mul_a, bus.mul_w); end
    tick();
    drive({12'd0, 12'd4}, {12'd0, 12'd3}, MODE_D, 2'b00, 1'b1);
    settle();
    checks++; if (bus.mul_mode !== 1'b0) begin errors++; $display("FAIL mh_mode_last: got %b expected 0", bus.mul_mode); end
    tick();
    drive({12'd0, 12'd9}, {12'd0, 12'd9}, MODE_K, 2'b00, 1'b1);
    ready_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
      tick();
    end
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL mh_drain_ready: got in_ready=1 during drain expected 0"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mh_drain_busy: got %b expected 1", busy); end
    bus.out_ready = 1'b1;
    j = 0;
    n = 0;
    new_taken = 1'b0;
    while (j < 4 && n < 40) begin
      settle();
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mh_ready_idle: got busy=%b when in_ready rose expected 0", busy); end
        new_taken = 1'b1;
      end
      if (bus.out_valid) begin
        checks++; if (bus.out_data !== exp_v[j]) begin errors++; $display("FAIL mh_data%0d: got %h expected %h", j, bus.out_data, exp_v[j]); end
        checks++; if (bus.out_last !== (j >= 2)) begin errors++; $display("FAIL mh_last%0d: got %b expected %b", j, bus.out_last, j >= 2); end
        j++;
      end
      tick();
      if (took) idle_in();
      n++;
    end
    idle_in();
    checks++; if (j != 4 || new_taken !== 1'b1) begin errors++; $display("FAIL mh_totals: got results=%0d new_taken=%b expected 4/1", j, new_taken); end
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mh_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic valid_seen;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive({12'd0, 12'(k + 1)}, {12'd0, 12'd5}, MODE_D, 2'b00, 1'b0);
      tick();
    end
    idle_in();
    rst = 1'b0;
    settle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst: got %b expected 0", bus.in_ready); end
    tick();
    rst = 1'b1;
    settle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    checks++; if (bus.mul_a !== 24'h0 || bus.mul_w !== 24'h0) begin errors++; $display("FAIL rm_mul_ops: got a=%h w=%h expected 0", bus.mul_a, bus.mul_w); end
    checks++; if (bus.mul_mode !== 1'b0 || bus.mul_sel_a !== 2'b00) begin errors++; $display("FAIL rm_mul_ctl: got mode=%b sel=%b expected 0/00", bus.mul_mode, bus.mul_sel_a); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after: got %b expected 1", bus.in_ready); end
    valid_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid !== 1'b0) valid_seen = 1'b1;
    end
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL rm_discard: got out_valid=1 after reset expected none"); end
  endtask

  initial begin
    idle_in();
    bus.out_ready = 1'b0;
    test_reset();
    test_k_single();
    test_d_mode();
    test_intt();
    test_backpressure();
    test_mode_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
